// File: rtl/cms_pkg.sv
// Shared definitions for the multi-range trace capture block: control register
// map, WFI opcode, trigger state encoding and range-config field layout.
package cms_pkg;

    localparam logic [7:0] CTRL_START_EN   = 8'h00;
    localparam logic [7:0] CTRL_END_EN     = 8'h01;
    localparam logic [7:0] CTRL_START_ADDR = 8'h02;
    localparam logic [7:0] CTRL_END_ADDR   = 8'h03;
    localparam logic [7:0] CTRL_WFI_CLR    = 8'h04;
    localparam logic [7:0] CTRL_REARM      = 8'h05;
    localparam logic [7:0] CTRL_RANGE_BASE = 8'h10;

    localparam int RANGE_STRIDE  = 4;
    localparam int RANGE_LO_OFS  = 0;
    localparam int RANGE_HI_OFS  = 1;
    localparam int RANGE_CFG_OFS = 2;

    localparam int RANGE_LO_EN_BIT = 0;
    localparam int RANGE_HI_EN_BIT = 1;
    localparam int RANGE_EXCL_BIT  = 2;

    localparam logic [31:0] WFI_INSTRUCTION = 32'h1050_0073;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACING = 2'd1,
        STOPPED = 2'd2
    } trig_state_t;

    function automatic logic [7:0] range_addr(input int idx, input int ofs);
        return 8'(int'(CTRL_RANGE_BASE) + idx * RANGE_STRIDE + ofs);
    endfunction

endpackage

// File: rtl/cms_sync_fifo.sv
// Synchronous packet FIFO with a registered output stage. The output register
// counts towards DEPTH, so full means DEPTH entries are held in total.
module cms_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      mem_cnt;
    logic [AW:0]      occ;
    logic             out_valid;
    logic             pop;
    logic             push;
    logic             load;

    // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign pop   = out_valid & rd_en;
    assign full  = (occ == (AW+1)'(DEPTH));
    assign push  = wr_en & (~full | pop);
    assign load  = (mem_cnt != '0) & (~out_valid | pop);
    assign empty = ~out_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            occ       <= '0;
            out_valid <= 1'b0;
            rd_data   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_data   <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            mem_cnt <= mem_cnt + (AW+1)'(push) - (AW+1)'(load);
            occ     <= occ + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

endmodule

// File: rtl/cms_multi_range_tracer.sv
// Trace capture: start/end trigger FSM, address windows and WFI stop qualify
// the retire stream into a FIFO feeding an AXI-Stream master.
// Optional CMS_DROP_COUNTER_EN: counts packets lost to a full FIFO on dropped_count.
module cms_multi_range_tracer
    import cms_pkg::*;
#(
    parameter int XLEN            = 64,
    parameter int TS_WIDTH        = 64,
    parameter int NUM_RANGES      = 4,
    parameter int FIFO_DEPTH      = 16,
    parameter int ONESHOT         = 0,
    parameter int CTRL_WE_POSEDGE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [31:0]                  instr,
    input  logic [XLEN-1:0]              pc,
    input  logic                         pc_valid,
    input  logic [7:0]                   ctrl_addr,
    input  logic [63:0]                  ctrl_wdata,
    input  logic                         ctrl_write_enable,
    input  logic [31:0]                  tlast_interval,
    output logic                         M_AXIS_tvalid,
    input  logic                         M_AXIS_tready,
    output logic [32+TS_WIDTH+XLEN-1:0]  M_AXIS_tdata,
    output logic                         M_AXIS_tlast,
    output logic [1:0]                   trig_state,
    output logic [31:0]                  dropped_count
);

    localparam int PKT_W = 1 + 32 + TS_WIDTH + XLEN;

    logic                ctrl_we_q;
    logic                ctrl_wr;
    logic [XLEN-1:0]     wdata_x;
    logic                start_en;
    logic                end_en;
    logic [XLEN-1:0]     start_addr;
    logic [XLEN-1:0]     end_addr;
    logic [XLEN-1:0]     range_lo  [NUM_RANGES];
    logic [XLEN-1:0]     range_hi  [NUM_RANGES];
    logic [2:0]          range_cfg [NUM_RANGES];

    assign ctrl_wr = ctrl_write_enable & ((CTRL_WE_POSEDGE == 0) | ~ctrl_we_q);
    assign wdata_x = XLEN'(ctrl_wdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_we_q  <= 1'b0;
            start_en   <= 1'b0;
            end_en     <= 1'b0;
            start_addr <= '0;
            end_addr   <= '1;
            for (int i = 0; i < NUM_RANGES; i++) begin
                range_lo[i]  <= '0;
                range_hi[i]  <= '1;
                range_cfg[i] <= '0;
            end
        end else begin
            ctrl_we_q <= ctrl_write_enable;
            if (ctrl_wr) begin
                case (ctrl_addr)
                    CTRL_START_EN:   start_en   <= ctrl_wdata[0];
                    CTRL_END_EN:     end_en     <= ctrl_wdata[0];
                    CTRL_START_ADDR: start_addr <= wdata_x;
                    CTRL_END_ADDR:   end_addr   <= wdata_x;
                    default: ;
                endcase
                for (int i = 0; i < NUM_RANGES; i++) begin
                    if (ctrl_addr == range_addr(i, RANGE_LO_OFS))  range_lo[i]  <= wdata_x;
                    if (ctrl_addr == range_addr(i, RANGE_HI_OFS))  range_hi[i]  <= wdata_x;
                    if (ctrl_addr == range_addr(i, RANGE_CFG_OFS)) range_cfg[i] <= ctrl_wdata[2:0];
                end
            end
        end
    end

    // Trigger FSM; a control write in the same cycle overrides trigger evaluation.
    trig_state_t state;
    logic        pc_is_start;
    logic        idle_go;
    logic        restart_go;
    logic        stop_hit;
    logic        fsm_qual;

    assign pc_is_start = pc_valid & (pc == start_addr);
    assign idle_go     = ~start_en | pc_is_start;
    assign restart_go  = (ONESHOT == 0) & start_en & pc_is_start;
    assign stop_hit    = end_en & pc_valid & (pc == end_addr);
    assign fsm_qual    = (state == TRACING) |
                         (~ctrl_wr & (((state == IDLE) & idle_go) | ((state == STOPPED) & restart_go)));
    assign trig_state  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (ctrl_wr) begin
            if (ctrl_addr == CTRL_REARM) state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (idle_go)    state <= TRACING;
                TRACING: if (stop_hit)   state <= STOPPED;
                STOPPED: if (restart_go) state <= TRACING;
                default: state <= IDLE;
            endcase
        end
    end

    logic [NUM_RANGES-1:0] win_active;
    logic [NUM_RANGES-1:0] win_match;
    logic [NUM_RANGES-1:0] win_excl;
    logic                  range_pass;

    for (genvar g = 0; g < NUM_RANGES; g++) begin : g_win
        assign win_active[g] = range_cfg[g][RANGE_LO_EN_BIT] | range_cfg[g][RANGE_HI_EN_BIT];
        assign win_match[g]  = ((pc >= range_lo[g]) | ~range_cfg[g][RANGE_LO_EN_BIT]) &
                               ((pc <= range_hi[g]) | ~range_cfg[g][RANGE_HI_EN_BIT]);
        assign win_excl[g]   = range_cfg[g][RANGE_EXCL_BIT];
    end

    assign range_pass = (~|(win_active & ~win_excl) | |(win_active & ~win_excl & win_match)) &
                        ~|(win_active & win_excl & win_match);

    // WFI stop latches at 2 and only a WFI-clear write releases it.
    logic [1:0] wfi_cnt;
    logic       is_wfi;
    logic       wfi_blocked;

    assign is_wfi      = (instr == WFI_INSTRUCTION);
    assign wfi_blocked = (wfi_cnt == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            wfi_cnt <= '0;
        end else if (ctrl_wr && ctrl_addr == CTRL_WFI_CLR) begin
            wfi_cnt <= '0;
        end else if (!wfi_blocked) begin
            if (!is_wfi)  wfi_cnt <= '0;
            else if (en)  wfi_cnt <= wfi_cnt + 2'd1;
        end
    end

    logic                accept;
    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] last_ts;
    logic [TS_WIDTH-1:0] delta;
    logic [31:0]         pkt_cnt;
    logic                pkt_tlast;

    assign accept    = en & pc_valid & fsm_qual & range_pass & ~wfi_blocked;
    assign delta     = (ts >= last_ts) ? (ts - last_ts) : '1;
    assign pkt_tlast = is_wfi |
                       ((tlast_interval != '0) & (({1'b0, pkt_cnt} + 33'd1) >= {1'b0, tlast_interval}));

    always_ff @(posedge clk) begin
        if (rst) begin
            ts      <= '0;
            last_ts <= '0;
            pkt_cnt <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (accept) begin
                last_ts <= ts;
                pkt_cnt <= pkt_tlast ? '0 : pkt_cnt + 32'd1;
            end
        end
    end

    // AXIS master: a beat transfers when tvalid & tready at a clock edge; tvalid
    // never waits on tready, and tdata/tlast hold while tvalid & ~tready.
    logic [PKT_W-1:0] fifo_rd;
    logic             fifo_empty;
`ifdef CMS_DROP_COUNTER_EN
    logic             fifo_full;
`endif

    cms_sync_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_data ({pkt_tlast, instr, delta, pc}),
`ifdef CMS_DROP_COUNTER_EN
        .full    (fifo_full),
`else
        .full    (),
`endif
        .rd_en   (M_AXIS_tready),
        .rd_data (fifo_rd),
        .empty   (fifo_empty)
    );

    assign M_AXIS_tvalid = ~fifo_empty;
    assign M_AXIS_tlast  = fifo_rd[PKT_W-1];
    assign M_AXIS_tdata  = fifo_rd[PKT_W-2:0];

`ifdef CMS_DROP_COUNTER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dropped_count <= '0;
        end else if (accept && fifo_full && !(M_AXIS_tvalid && M_AXIS_tready) && dropped_count != '1) begin
            dropped_count <= dropped_count + 32'd1;
        end
    end
`else
    assign dropped_count = '0;
`endif

endmodule
